seq_detector_param: RTL and testbench

//  Parametrised serial pattern detector. Next generation of the FSM1 sequence detector.

---
 rtl/seq_detector_param_if.sv | 32 +++
 rtl/seq_detector_param.sv | 108 ++++++++++
 tb/tb_seq_detector_param.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_detector_param_if.sv
//----------------------------------------------------------------------
// seq_detector_param_if : sample/control/result bundle for the detector
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

interface seq_detector_param_if #(
   parameter int PAT_W   = 4,
   parameter int COUNT_W = 8
);
   logic               in_valid;
   logic               in_seq;
   logic               overlap;
   logic               pat_load;
   logic [PAT_W-1:0]   pat_in;
   logic               cnt_clr;
   logic               mealy_y;
   logic               moore_y;
   logic [COUNT_W-1:0] match_cnt;

   modport master (
      output in_valid, in_seq, overlap, pat_load, pat_in, cnt_clr,
      input  mealy_y, moore_y, match_cnt
   );

   modport slave (
      input  in_valid, in_seq, overlap, pat_load, pat_in, cnt_clr,
      output mealy_y, moore_y, match_cnt
   );
endinterface

`default_nettype wire

// File: rtl/seq_detector_param.sv
//----------------------------------------------------------------------
// seq_detector_param : serial pattern detector, Moore + Mealy flags,
// runtime pattern reload, overlap mode, optional match counter
// (SEQ_DET_CNT_EN). Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module seq_detector_param #(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
   parameter int               COUNT_W = 8
) (
   input  wire logic          clk,
   input  wire logic          reset,
   seq_detector_param_if.slave bus
);

   localparam int              FILL_W   = $clog2(PAT_W);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      MATCH = 1'b1
   } state_t;

   state_t             state;
   logic [PAT_W-2:0]   hist;
   logic [FILL_W-1:0]  fill;
   logic [PAT_W-1:0]   pat;
   logic               moore_q;

   logic               accepted;
   logic               hit;
   logic [PAT_W-2:0]   hist_shift;
   logic [FILL_W-1:0]  fill_next;

   assign accepted  = bus.in_valid && !bus.pat_load;
   assign hit       = accepted && (fill == FILL_MAX) && ({hist, bus.in_seq} == pat);
   assign fill_next = (fill == FILL_MAX) ? FILL_MAX : fill + 1'b1;

   // A 2-bit pattern keeps only one history bit, so there is nothing to shift.
   generate
      if (PAT_W > 2) begin : g_shift_wide
         assign hist_shift = {hist[PAT_W-3:0], bus.in_seq};
      end else begin : g_shift_narrow
         assign hist_shift = bus.in_seq;
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist    <= '0;
         fill    <= '0;
         pat     <= PATTERN;
         state   <= IDLE;
         moore_q <= 1'b0;
      end else if (bus.pat_load) begin
         pat     <= bus.pat_in;
         hist    <= '0;
         fill    <= '0;
         state   <= IDLE;
         moore_q <= 1'b0;
      end else if (bus.in_valid) begin
         if (hit && !bus.overlap) begin
            hist <= '0;
            fill <= '0;
         end else begin
            hist <= hist_shift;
            fill <= fill_next;
         end
         state   <= hit ? MATCH : IDLE;
         moore_q <= hit;
      end
   end

   assign bus.mealy_y = hit && reset;
   assign bus.moore_y = moore_q;

`ifdef SEQ_DET_CNT_EN
   localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

   logic [COUNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (bus.cnt_clr) begin
         cnt <= '0;
      end else if (hit && (cnt != CNT_MAX)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign bus.match_cnt = cnt;
`else
   logic unused_cnt_clr;

   assign unused_cnt_clr = bus.cnt_clr;
   assign bus.match_cnt  = '0;
`endif

   logic unused_state;

   assign unused_state = (state == MATCH);

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
//----------------------------------------------------------------------
// tb_seq_detector_param : scoreboard bench, COUNT_W=8 and COUNT_W=2 DUTs
// driven by one stream. Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module tb_seq_detector_param;

`ifdef SEQ_DET_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic clk;
   logic rst_n;

   seq_detector_param_if #(.PAT_W(4), .COUNT_W(8)) ifa ();
   seq_detector_param_if #(.PAT_W(4), .COUNT_W(2)) ifb ();

   seq_detector_param #(.PAT_W(4), .PATTERN(4'b1101), .COUNT_W(8)) dut_a (
      .clk   (clk),
      .reset (rst_n),
      .bus   (ifa)
   );

   seq_detector_param #(.PAT_W(4), .PATTERN(4'b1101), .COUNT_W(2)) dut_b (
      .clk   (clk),
      .reset (rst_n),
      .bus   (ifb)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
      $fatal(1, "watchdog");
   end

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] exp_q[$];

   // reference model state
   bit         hq[$];
   logic [3:0] mpat;
   bit         mstate;
   int         mcnt8;
   int         mcnt2;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_pop(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         e = 32'hDEAD_BEEF;
      end else begin
         e = exp_q.pop_front();
      end
      check(tag, obs, e);
   endtask

   function automatic void model_reset();
      hq.delete();
      mpat   = 4'b1101;
      mstate = 1'b0;
      mcnt8  = 0;
      mcnt2  = 0;
   endfunction

   function automatic bit model_hit(input bit v, input bit s, input bit ld);
      logic [3:0] w;
      int n;
      n = hq.size();
      if (!v || ld || n < 3) return 1'b0;
      w = {hq[n-3], hq[n-2], hq[n-1], s};
      return (w == mpat);
   endfunction

   function automatic void model_update(input bit v, input bit s, input bit ld,
                                        input logic [3:0] pin, input bit clr,
                                        input bit ov, input bit h);
      if (ld) begin
         mpat = pin;
         hq.delete();
         mstate = 1'b0;
      end else if (v) begin
         if (h && !ov) begin
            hq.delete();
         end else begin
            hq.push_back(s);
            if (hq.size() > 3) void'(hq.pop_front());
         end
         mstate = h;
      end
      if (CNT_EN) begin
         if (clr) begin
            mcnt8 = 0;
            mcnt2 = 0;
         end else if (h) begin
            if (mcnt8 < 255) mcnt8++;
            if (mcnt2 < 3)   mcnt2++;
         end
      end
   endfunction

   task automatic drive(input bit v, input bit s, input bit ld, input logic [3:0] pin,
                        input bit clr, input bit ov);
      ifa.in_valid = v;   ifb.in_valid = v;
      ifa.in_seq   = s;   ifb.in_seq   = s;
      ifa.pat_load = ld;  ifb.pat_load = ld;
      ifa.pat_in   = pin; ifb.pat_in   = pin;
      ifa.cnt_clr  = clr; ifb.cnt_clr  = clr;
      ifa.overlap  = ov;  ifb.overlap  = ov;
   endtask

   bit ov_cur = 1'b1;

   // One clock: Mealy checked before the edge, registered outputs after it.
   task automatic cycle(input bit v, input bit s, input bit ld, input logic [3:0] pin,
                        input bit clr);
      bit h;
      drive(v, s, ld, pin, clr, ov_cur);
      #2;
      h = rst_n ? model_hit(v, s, ld) : 1'b0;
      exp_q.push_back(32'(h));
      chk_pop("mealy_a", 32'(ifa.mealy_y));
      exp_q.push_back(32'(h));
      chk_pop("mealy_b", 32'(ifb.mealy_y));
      @(posedge clk);
      #1;
      if (rst_n) model_update(v, s, ld, pin, clr, ov_cur, h);
      else       model_reset();
      exp_q.push_back(32'(mstate));
      chk_pop("moore_a", 32'(ifa.moore_y));
      exp_q.push_back(32'(mstate));
      chk_pop("moore_b", 32'(ifb.moore_y));
      exp_q.push_back(32'(mcnt8));
      chk_pop("cnt_a", 32'(ifa.match_cnt));
      exp_q.push_back(32'(mcnt2));
      chk_pop("cnt_b", 32'(ifb.match_cnt));
   endtask

   task automatic stream(input logic [15:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) cycle(1'b1, bits[i], 1'b0, 4'b0000, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, 4'b0000, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cycle(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
      rst_n = 1'b1;
   endtask

   // Reset asserted between edges must clear registered outputs immediately.
   task automatic async_reset_check();
      rst_n = 1'b0;
      #1;
      model_reset();
      exp_q.push_back(32'(0));
      chk_pop("async_moore_a", 32'(ifa.moore_y));
      exp_q.push_back(32'(0));
      chk_pop("async_mealy_a", 32'(ifa.mealy_y));
      exp_q.push_back(32'(0));
      chk_pop("async_cnt_a", 32'(ifa.match_cnt));
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
      model_reset();
      #1;

      // 1: random inputs under reset, then first match
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
      rst_n = 1'b1;
      ov_cur = 1'b1;
      stream(16'b1101, 4);

      // 2: overlapping 1101101
      do_reset();
      ov_cur = 1'b1;
      stream(16'b1101101, 7);
      idle(1);

      // 3: non-overlapping 1101101
      do_reset();
      ov_cur = 1'b0;
      stream(16'b1101101, 7);

      // 4: valid gaps inside a match, moore held across idle cycles
      do_reset();
      ov_cur = 1'b1;
      stream(16'b11, 2);
      idle(3);
      stream(16'b01, 2);
      idle(5);
      stream(16'b0, 1);

      // 5: pattern reload discards the same-cycle sample
      do_reset();
      stream(16'b11, 2);
      cycle(1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
      stream(16'b0110, 4);
      stream(16'b1101, 4);
      stream(16'b1101101, 7);

      // 6: counter saturation and clear-with-hit priority
      do_reset();
      ov_cur = 1'b1;
      stream(16'b1101, 4);
      for (int k = 0; k < 4; k++) stream(16'b101, 3);
      stream(16'b10, 2);
      cycle(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
      stream(16'b101, 3);
      cycle(1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
      stream(16'b101, 3);
      async_reset_check();
      stream(16'b1101, 4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
